// File: rtl/output_diff_checker_if.sv
// Result-bus interface between the fuzz-simulation stimulus side and the
// output_diff_checker. The master drives the two compared buses plus the
// run/sample controls; the slave (the checker) returns its run status and
// the compact pass/fail result.
interface output_diff_checker_if #(
  parameter int WIDTH = 385
);
  logic             start;
  logic             sample_en;
  logic [WIDTH-1:0] y_a;
  logic [WIDTH-1:0] y_b;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [7:0]       first_idx;
  logic [8:0]       first_bit;
  logic [7:0]       mismatch_count;
  logic [31:0]      sig_a;
  logic [31:0]      sig_b;

  modport master (
    output start, sample_en, y_a, y_b,
    input  busy, done, mismatch, first_idx, first_bit, mismatch_count,
           sig_a, sig_b
  );

  modport slave (
    input  start, sample_en, y_a, y_b,
    output busy, done, mismatch, first_idx, first_bit, mismatch_count,
           sig_a, sig_b
  );
endinterface

// File: rtl/output_diff_checker.sv
// Compares two implementations' result buses sample by sample, folds each
// stream into a 32-bit MISR signature and records the first divergence
// (sample index and lowest differing bit) plus a saturating mismatch count.
//
// Handshake: there is no backpressure. A sample is taken on every rising
// edge where the FSM is in RUN and sample_en is high; sample_en in IDLE or
// DONE is ignored, and start is only honoured in IDLE or DONE (the edge that
// honours start never takes a sample).
module output_diff_checker #(
  parameter int          WIDTH   = 385,
  parameter int          SAMPLES = 21,
  parameter logic [31:0] POLY    = 32'h04C11DB7
) (
  input  logic                      clk,
  input  logic                      rst,
  output_diff_checker_if.slave      bus,
  output logic [1:0]                dbg_state_o
);

  localparam int         SEGS  = (WIDTH + 31) / 32;
  localparam int         PAD_W = SEGS * 32;
  localparam logic [7:0] LAST  = 8'(SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic        mismatch_q;
  logic [7:0]  first_idx_q;
  logic [8:0]  first_bit_q;
  logic [7:0]  mismatch_count_q;
  logic [31:0] sig_a_q;
  logic [31:0] sig_b_q;
  logic [7:0]  cnt_q;

  logic [WIDTH-1:0] diff_d;
  logic             diff_any_d;
  logic [8:0]       low_bit_d;
  logic [31:0]      sig_a_d;
  logic [31:0]      sig_b_d;
  logic             accept_d;

  // XOR of all 32-bit segments of the zero-padded bus.
  function automatic logic [31:0] fold(input logic [WIDTH-1:0] y);
    logic [PAD_W-1:0] p;
    logic [31:0]      f;
    p = '0;
    p[WIDTH-1:0] = y;
    f = '0;
    for (int k = 0; k < SEGS; k++) begin
      f = f ^ p[32*k +: 32];
    end
    return f;
  endfunction

  // One MISR step: shift left, feed back POLY on carry-out, absorb the fold.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] f);
    return {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ f;
  endfunction

  // Per-sample combinational work: difference vector, lowest differing bit
  // and the next signatures of both streams.
  always_comb begin
    diff_d     = bus.y_a ^ bus.y_b;
    diff_any_d = |diff_d;
    low_bit_d  = '0;
    // Scan downwards so the last hit (lowest index) wins.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff_d[i]) low_bit_d = 9'(i);
    end
    sig_a_d  = misr_next(sig_a_q, fold(bus.y_a));
    sig_b_d  = misr_next(sig_b_q, fold(bus.y_b));
    accept_d = (state_q == S_RUN) && bus.sample_en;
  end

  // Run FSM with all result registers; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mismatch_q       <= 1'b0;
      first_idx_q      <= '0;
      first_bit_q      <= '0;
      mismatch_count_q <= '0;
      sig_a_q          <= '0;
      sig_b_q          <= '0;
      cnt_q            <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q          <= S_RUN;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            mismatch_q       <= 1'b0;
            first_idx_q      <= '0;
            first_bit_q      <= '0;
            mismatch_count_q <= '0;
            sig_a_q          <= '0;
            sig_b_q          <= '0;
            cnt_q            <= '0;
          end
        end
        S_RUN: begin
          if (accept_d) begin
            sig_a_q <= sig_a_d;
            sig_b_q <= sig_b_d;
            cnt_q   <= cnt_q + 8'd1;
            if (diff_any_d) begin
              if (mismatch_count_q != 8'hFF) begin
                mismatch_count_q <= mismatch_count_q + 8'd1;
              end
              if (!mismatch_q) begin
                mismatch_q  <= 1'b1;
                first_idx_q <= cnt_q;
                first_bit_q <= low_bit_d;
              end
            end
            if (cnt_q == LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.first_idx      = first_idx_q;
  assign bus.first_bit      = first_bit_q;
  assign bus.mismatch_count = mismatch_count_q;
  assign bus.sig_a          = sig_a_q;
  assign bus.sig_b          = sig_b_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_output_diff_checker.sv
// Directed bench for output_diff_checker: one 21-sample instance for the
// main run behaviour and two small instances (2 and 1 samples) for the
// signature arithmetic and the single-sample boundary. All three share the
// same stimulus.
module tb_output_diff_checker;

  localparam int          WIDTH = 385;
  localparam logic [31:0] POLY  = 32'h04C11DB7;

  logic clk;
  logic rst;
  logic             start;
  logic             sample_en;
  logic [WIDTH-1:0] y_a;
  logic [WIDTH-1:0] y_b;

  logic [1:0] st1, st2, st3;

  int n_vec;
  int n_err;

  logic [31:0] sa;
  logic [31:0] sb;

  // Expected-value queue used as a tiny scoreboard for signatures.
  logic [31:0] exp_q[$];

  output_diff_checker_if #(.WIDTH(WIDTH)) if1 ();
  output_diff_checker_if #(.WIDTH(WIDTH)) if2 ();
  output_diff_checker_if #(.WIDTH(WIDTH)) if3 ();

  assign if1.start = start;  assign if1.sample_en = sample_en;
  assign if1.y_a   = y_a;    assign if1.y_b       = y_b;
  assign if2.start = start;  assign if2.sample_en = sample_en;
  assign if2.y_a   = y_a;    assign if2.y_b       = y_b;
  assign if3.start = start;  assign if3.sample_en = sample_en;
  assign if3.y_a   = y_a;    assign if3.y_b       = y_b;

  output_diff_checker #(.WIDTH(WIDTH), .SAMPLES(21), .POLY(POLY)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .dbg_state_o(st1));
  output_diff_checker #(.WIDTH(WIDTH), .SAMPLES(2), .POLY(POLY)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .dbg_state_o(st2));
  output_diff_checker #(.WIDTH(WIDTH), .SAMPLES(1), .POLY(POLY)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .dbg_state_o(st3));

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference fold: bit i of the bus lands on bit i mod 32.
  function automatic logic [31:0] fold_m(input logic [WIDTH-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] misr_m(input logic [31:0] s,
                                         input logic [WIDTH-1:0] y);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ fold_m(y);
  endfunction

  function automatic logic [WIDTH-1:0] rand_y();
    logic [415:0] t;
    for (int k = 0; k < 13; k++) t[32*k +: 32] = $urandom;
    return t[WIDTH-1:0];
  endfunction

  // Driver: present one sample (optionally with start) and clock it in.
  task automatic drive_sample(input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic st);
    y_a = a; y_b = b; sample_en = 1'b1; start = st;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  if1.busy, 0);
    chk({tag, "_done"},  if1.done, 0);
    chk({tag, "_mm"},    if1.mismatch, 0);
    chk({tag, "_idx"},   if1.first_idx, 0);
    chk({tag, "_bit"},   if1.first_bit, 0);
    chk({tag, "_cnt"},   if1.mismatch_count, 0);
    chk({tag, "_siga"},  if1.sig_a, 0);
    chk({tag, "_sigb"},  if1.sig_b, 0);
    chk({tag, "_state"}, st1, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] one;
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; sample_en = 1'b0; y_a = '0; y_b = '0;
    one = '0; one[0] = 1'b1;

    // 1) Reset then idle traffic without start.
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y_a = rand_y(); y_b = rand_y(); sample_en = 1'b1;
      tick();
    end
    check_all_zero("idle_noise");

    // 2) Matching zero streams; the start edge carries a sample that is dropped.
    drive_sample(one, one, 1'b1);
    chk("start_busy", if1.busy, 1);
    chk("start_state", st1, 1);
    chk("start_no_sample", if1.sig_a, 0);
    for (int i = 0; i < 21; i++) begin
      drive_sample('0, '0, 1'b0);
      if (i == 19) chk("zero_not_done", if1.done, 0);
    end
    chk("zero_done", if1.done, 1);
    chk("zero_busy", if1.busy, 0);
    chk("zero_state", st1, 2);
    chk("zero_mm", if1.mismatch, 0);
    chk("zero_cnt", if1.mismatch_count, 0);
    chk("zero_siga", if1.sig_a, 0);
    chk("zero_sigb", if1.sig_b, 0);

    // 3) Signature arithmetic on the 2-sample and 1-sample instances.
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    for (int rep = 0; rep < 2; rep++) begin
      a = '0;
      if (rep == 0) a[0] = 1'b1; else a[WIDTH-1] = 1'b1;
      start = 1'b1; sample_en = 1'b0;
      tick();
      start = 1'b0;
      chk("sig_clear", if2.sig_a, 0);
      chk("sig_busy", if2.busy, 1);
      drive_sample(a, a, 1'b0);
      chk("sig_s1_a", if2.sig_a, exp_q.pop_front());
      chk("sig_s1_b", if2.sig_b, 32'h1);
      chk("sig_s1_notdone", if2.done, 0);
      chk("one_sample_done", if3.done, 1);
      chk("one_sample_sig", if3.sig_a, 32'h1);
      drive_sample('0, '0, 1'b0);
      chk("sig_s2_a", if2.sig_a, exp_q.pop_front());
      chk("sig_s2_done", if2.done, 1);
      chk("sig_s2_busy", if2.busy, 0);
    end
    rst = 1'b1; tick(); rst = 1'b0;

    // 4) First-mismatch capture with start during RUN and a sample_en gap.
    start = 1'b1; sample_en = 1'b0;
    tick();
    start = 1'b0;
    sa = '0; sb = '0;
    for (int i = 0; i < 21; i++) begin
      b = rand_y(); a = b;
      if (i == 5) a[200] = ~a[200];
      if (i == 9) a[3] = ~a[3];
      drive_sample(a, b, i == 10);
      sa = misr_m(sa, a); sb = misr_m(sb, b);
      if (i == 5) begin
        chk("mm_flag", if1.mismatch, 1);
        chk("mm_idx", if1.first_idx, 5);
        chk("mm_bit", if1.first_bit, 200);
        chk("mm_cnt1", if1.mismatch_count, 1);
      end
      if (i == 9) begin
        chk("mm_cnt2", if1.mismatch_count, 2);
        chk("mm_bit_kept", if1.first_bit, 200);
      end
      if (i == 10) begin
        chk("run_start_busy", if1.busy, 1);
        chk("run_start_idx", if1.first_idx, 5);
        chk("run_start_sig", if1.sig_a, sa);
      end
      if (i == 12) begin
        sample_en = 1'b0;
        for (int g = 0; g < 4; g++) begin
          y_a = rand_y(); y_b = rand_y();
          tick();
        end
        chk("gap_busy", if1.busy, 1);
        chk("gap_sig", if1.sig_a, sa);
        chk("gap_cnt", if1.mismatch_count, 2);
      end
      if (i == 19) chk("mm_not_done", if1.done, 0);
    end
    chk("mm_done", if1.done, 1);
    chk("mm_final_cnt", if1.mismatch_count, 2);
    chk("mm_final_idx", if1.first_idx, 5);
    chk("mm_final_flag", if1.mismatch, 1);
    chk("mm_siga", if1.sig_a, sa);
    chk("mm_sigb", if1.sig_b, sb);

    // 5) Start in DONE clears results on the same edge; then reset mid-run.
    a = rand_y(); b = ~a;
    drive_sample(a, b, 1'b1);
    chk("restart_state", st1, 1);
    chk("restart_done", if1.done, 0);
    chk("restart_mm", if1.mismatch, 0);
    chk("restart_cnt", if1.mismatch_count, 0);
    chk("restart_idx", if1.first_idx, 0);
    chk("restart_bit", if1.first_bit, 0);
    chk("restart_sig", if1.sig_a, 0);
    for (int i = 0; i < 7; i++) begin
      b = rand_y(); a = b;
      if (i == 2) a[100] = ~a[100];
      drive_sample(a, b, 1'b0);
    end
    chk("pre_rst_mm", if1.mismatch, 1);
    chk("pre_rst_idx", if1.first_idx, 2);
    chk("pre_rst_bit", if1.first_bit, 100);
    rst = 1'b1;
    tick();
    check_all_zero("midrun_rst");
    rst = 1'b0;
    start = 1'b1; sample_en = 1'b0;
    tick();
    start = 1'b0;
    sa = '0;
    for (int i = 0; i < 21; i++) begin
      a = rand_y();
      drive_sample(a, a, 1'b0);
      sa = misr_m(sa, a);
    end
    chk("clean_done", if1.done, 1);
    chk("clean_mm", if1.mismatch, 0);
    chk("clean_cnt", if1.mismatch_count, 0);
    chk("clean_siga", if1.sig_a, sa);
    chk("clean_sigb", if1.sig_b, sa);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
